// File: rtl/cc_request_encoder_pkg.sv
// Shared constants and types for the request encoder slice.
// Selection-mode constants feed the ROUND_ROBIN parameter of cc_request_encoder.
package cc_request_encoder_pkg;

  localparam int CC_ENC_FIXED       = 0;
  localparam int CC_ENC_ROUND_ROBIN = 1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } cc_enc_state_e;

endpackage

// File: rtl/cc_priority_encoder.sv
// Combinational wrap-around priority encoder.
// Reports the first set bit at or after start, wrapping to bit 0.
module cc_priority_encoder #(
  parameter int IDX_WIDTH = 3,
  parameter int REQ_WIDTH = 1 << IDX_WIDTH
) (
  input  logic [REQ_WIDTH-1:0] vector,
  input  logic [IDX_WIDTH-1:0] start,
  output logic                 found,
  output logic [IDX_WIDTH-1:0] index
);

  logic                 found_hi;
  logic [IDX_WIDTH-1:0] index_hi;
  logic                 found_lo;
  logic [IDX_WIDTH-1:0] index_lo;

  // Upper pass covers [start, REQ_WIDTH); lower pass is the wrapped remainder.
  always_comb begin
    found_hi = 1'b0;
    index_hi = '0;
    found_lo = 1'b0;
    index_lo = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      if (!found_hi && vector[i] && (i >= int'(start))) begin
        found_hi = 1'b1;
        index_hi = IDX_WIDTH'(i);
      end
      if (!found_lo && vector[i]) begin
        found_lo = 1'b1;
        index_lo = IDX_WIDTH'(i);
      end
    end
  end

  assign found = found_hi | found_lo;
  assign index = found_hi ? index_hi : index_lo;

endmodule

// File: rtl/cc_request_encoder.sv
// Registered 2^N-to-N request encoder with valid/ack handshake.
// Event pulses collect in a pending set; one eligible source is presented at a time.
module cc_request_encoder
  import cc_request_encoder_pkg::*;
#(
  parameter int IDX_WIDTH   = 3,
  parameter int REQ_WIDTH   = 1 << IDX_WIDTH,
  parameter int ROUND_ROBIN = CC_ENC_FIXED
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REQ_WIDTH-1:0] req,
  input  logic [REQ_WIDTH-1:0] mask,
  input  logic                 ack,
  output logic                 valid,
  output logic [IDX_WIDTH-1:0] index,
  output logic [REQ_WIDTH-1:0] pending
);

  localparam bit RR_MODE = (ROUND_ROBIN == CC_ENC_ROUND_ROBIN);

  cc_enc_state_e        state;
  logic [IDX_WIDTH-1:0] rr_ptr;
  logic                 take;
  logic [IDX_WIDTH-1:0] idx_inc;
  logic [REQ_WIDTH-1:0] clr;
  logic [REQ_WIDTH-1:0] pending_nxt;
  logic [REQ_WIDTH-1:0] elig;
  logic [IDX_WIDTH-1:0] scan_start;
  logic                 sel_found;
  logic [IDX_WIDTH-1:0] sel_index;

  assign take    = valid & ack;
  assign idx_inc = (int'(index) == REQ_WIDTH - 1) ? '0 : index + IDX_WIDTH'(1);

  always_comb begin
    clr = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      if (take && (index == IDX_WIDTH'(i))) clr[i] = 1'b1;
    end
  end

  // A re-request in the ack cycle beats the clear, so the bit stays pending.
  assign pending_nxt = (pending & ~clr) | req;
  assign elig        = pending_nxt & ~mask;

  // Back-to-back grants scan from the pointer that this very ack produces.
  assign scan_start = RR_MODE ? (take ? idx_inc : rr_ptr) : '0;

  cc_priority_encoder #(
    .IDX_WIDTH (IDX_WIDTH),
    .REQ_WIDTH (REQ_WIDTH)
  ) u_prio (
    .vector (elig),
    .start  (scan_start),
    .found  (sel_found),
    .index  (sel_index)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      index   <= '0;
      rr_ptr  <= '0;
      pending <= '0;
    end else begin
      pending <= pending_nxt;
      if (take) rr_ptr <= idx_inc;
      case (state)
        ST_IDLE: begin
          if (sel_found) begin
            state <= ST_PRESENT;
            index <= sel_index;
          end
        end
        ST_PRESENT: begin
          if (ack) begin
            if (sel_found) index <= sel_index;
            else           state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign valid = (state == ST_PRESENT);

endmodule

// File: tb/tb_cc_request_encoder.sv
// Bench for cc_request_encoder: fixed and rotating instances share stimulus,
// compared each cycle against a queue-free set/scan reference model.
module tb_cc_request_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack;
  logic       v_f, v_r;
  logic [2:0] i_f, i_r;
  logic [7:0] p_f, p_r;

  int total = 0;
  int bad   = 0;

  // Reference state: [0] = fixed priority, [1] = rotating priority.
  bit       m_val [2];
  int       m_idx [2];
  int       m_ptr [2];
  bit [7:0] m_pend[2];

  always #5 clk = ~clk;

  cc_request_encoder #(.IDX_WIDTH(3), .REQ_WIDTH(8), .ROUND_ROBIN(0)) u_fix (
    .clk(clk), .reset(reset), .req(req), .mask(mask), .ack(ack),
    .valid(v_f), .index(i_f), .pending(p_f)
  );

  cc_request_encoder #(.IDX_WIDTH(3), .REQ_WIDTH(8), .ROUND_ROBIN(1)) u_rr (
    .clk(clk), .reset(reset), .req(req), .mask(mask), .ack(ack),
    .valid(v_r), .index(i_r), .pending(p_r)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_val[m] = 0; m_idx[m] = 0; m_ptr[m] = 0; m_pend[m] = '0;
    end
  endtask

  // Set semantics: clear the acked source, add new requests, hand out the
  // first unmasked source in scan order (fixed: from 0; rotating: from pointer).
  task automatic model_step(input bit [7:0] r, input bit [7:0] mk, input bit a);
    bit [7:0] pn;
    bit [7:0] el;
    bit       took;
    int       st;
    int       p;
    for (int m = 0; m < 2; m++) begin
      took = m_val[m] && a;
      pn = m_pend[m];
      if (took) pn[m_idx[m]] = 1'b0;
      pn = pn | r;
      el = pn & ~mk;
      if (took) m_ptr[m] = (m_idx[m] + 1) % 8;
      if (!m_val[m] || took) begin
        st = (m == 1) ? m_ptr[m] : 0;
        m_val[m] = 0;
        for (int k = 0; k < 8; k++) begin
          p = (st + k) % 8;
          if (!m_val[m] && el[p]) begin
            m_val[m] = 1;
            m_idx[m] = p;
          end
        end
      end
      m_pend[m] = pn;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".fix.valid"},   32'(v_f), 32'(m_val[0]));
    chk({tag, ".fix.index"},   32'(i_f), 32'(m_idx[0]));
    chk({tag, ".fix.pending"}, 32'(p_f), 32'(m_pend[0]));
    chk({tag, ".rr.valid"},    32'(v_r), 32'(m_val[1]));
    chk({tag, ".rr.index"},    32'(i_r), 32'(m_idx[1]));
    chk({tag, ".rr.pending"},  32'(p_r), 32'(m_pend[1]));
  endtask

  // Drive one cycle of inputs, let the edge happen, compare 1 time unit later.
  task automatic tick(input string tag, input bit [7:0] r, input bit [7:0] mk, input bit a);
    req = r; mask = mk; ack = a;
    model_step(r, mk, a);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    reset = 1'b1; req = '0; mask = '0; ack = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("reset.valid",   32'(v_f), 0);
    chk("reset.pending", 32'(p_f), 0);
    chk("reset.index",   32'(i_f), 0);
    chk("reset.rr_valid", 32'(v_r), 0);
    #3 reset = 1'b0;
    @(posedge clk); #1;

    // Single request, one-cycle latency, then ack drains it.
    tick("basic_req", 8'h10, 8'h00, 1'b0);
    chk("basic.valid", 32'(v_f), 1);
    chk("basic.index", 32'(i_f), 4);
    chk("basic.pending", 32'(p_f), 32'h10);
    tick("basic_ack", 8'h00, 8'h00, 1'b1);
    chk("basic_ack.valid", 32'(v_f), 0);
    chk("basic_ack.pending", 32'(p_f), 0);

    // Fixed priority ordering 2, 5, 7 with no bubble.
    tick("fixed_req", 8'hA4, 8'h00, 1'b0);
    chk("fixed.idx0", 32'(i_f), 2);
    tick("fixed_ack1", 8'h00, 8'h00, 1'b1);
    chk("fixed.idx1", 32'(i_f), 5);
    chk("fixed.valid1", 32'(v_f), 1);
    tick("fixed_ack2", 8'h00, 8'h00, 1'b1);
    chk("fixed.idx2", 32'(i_f), 7);
    chk("fixed.valid2", 32'(v_f), 1);
    tick("fixed_ack3", 8'h00, 8'h00, 1'b1);
    chk("fixed.drained", 32'(v_f), 0);
    // Drain the rotating instance too (it saw the same set in another order).
    while (v_r) tick("rr_drain", 8'h00, 8'h00, 1'b1);

    // Rotating priority: after granting 5 the scan begins at 6 and wraps to 0.
    tick("rr_grant5", 8'h20, 8'h00, 1'b0);
    chk("rr.idx5", 32'(i_r), 5);
    tick("rr_ack5", 8'h00, 8'h00, 1'b1);
    tick("rr_req21", 8'h21, 8'h00, 1'b0);
    chk("rr.wrap_idx0", 32'(i_r), 0);
    tick("rr_rereq5", 8'h20, 8'h00, 1'b1);
    chk("rr.idx5_again", 32'(i_r), 5);
    chk("rr.valid_again", 32'(v_r), 1);
    tick("rr_drain1", 8'h00, 8'h00, 1'b1);
    while (v_f || v_r) tick("rr_drain2", 8'h00, 8'h00, 1'b1);

    // Re-request during ack keeps the bit pending and re-presents it.
    tick("simul_req", 8'h08, 8'h00, 1'b0);
    chk("simul.idx3", 32'(i_f), 3);
    tick("simul_ack", 8'h08, 8'h00, 1'b1);
    chk("simul.pending3", 32'(p_f[3]), 1);
    chk("simul.valid", 32'(v_f), 1);
    chk("simul.idx3_again", 32'(i_f), 3);
    tick("simul_drain", 8'h00, 8'h00, 1'b1);

    // Masked bit stays pending and is picked up once the mask drops.
    tick("mask_req", 8'h06, 8'h02, 1'b0);
    chk("mask.idx2", 32'(i_f), 2);
    tick("mask_ack", 8'h00, 8'h02, 1'b1);
    chk("mask.valid0", 32'(v_f), 0);
    chk("mask.pending", 32'(p_f), 32'h02);
    tick("mask_drop", 8'h00, 8'h00, 1'b0);
    chk("mask.valid1", 32'(v_f), 1);
    chk("mask.idx1", 32'(i_f), 1);
    tick("mask_drain", 8'h00, 8'h00, 1'b1);

    // Asynchronous reset in the middle of a handshake.
    tick("areset_req", 8'h0C, 8'h00, 1'b0);
    chk("areset.pre_valid", 32'(v_f), 1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("areset.valid_async", 32'(v_f), 0);
    chk("areset.pending_async", 32'(p_f), 0);
    chk("areset.rr_valid_async", 32'(v_r), 0);
    req = 8'hFF;
    @(posedge clk); #1;
    chk("areset.held_valid", 32'(v_f), 0);
    chk("areset.held_pending", 32'(p_r), 0);
    req = 8'h00;
    #3 reset = 1'b0;
    tick("areset_release", 8'h00, 8'h00, 1'b0);
    chk("areset.after_valid", 32'(v_f), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bit [7:0] r;
      bit [7:0] mk;
      bit       a;
      r  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      mk = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      a  = 1'($urandom_range(0, 1));
      tick("random", r, mk, a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
